// File: rtl/load_resp_if.sv
// Request (LSQ side) and CDB broadcast signal bundle for the load/store response stage.
// With LOAD_RESP_RVFI_EN defined, also provides the RVFI record type used by load_resp.

`ifdef LOAD_RESP_RVFI_EN
package load_resp_rvfi_pkg;
    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
        logic [31:0] dmem_rdata;
    } rvfi_data;
endpackage
`endif

interface load_resp_if #(
    parameter int ROB_IDX_W = 4,
    parameter int PREG_W    = 6
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_is_load;
    logic [2:0]           req_funct3;
    logic [1:0]           req_addr_lo;
    logic [ROB_IDX_W-1:0] req_rob_idx;
    logic [PREG_W-1:0]    req_pd;
    logic [4:0]           req_rd;

    logic                 cdb_valid;
    logic                 cdb_ready;
    logic [31:0]          cdb_value;
    logic [ROB_IDX_W-1:0] cdb_rob_idx;
    logic [PREG_W-1:0]    cdb_pd;
    logic [4:0]           cdb_rd;

    // master: the LSQ / CDB arbiter side; slave: the response stage itself
    modport master (
        output req_valid, req_is_load, req_funct3, req_addr_lo, req_rob_idx, req_pd, req_rd,
        output cdb_ready,
        input  req_ready,
        input  cdb_valid, cdb_value, cdb_rob_idx, cdb_pd, cdb_rd
    );

    modport slave (
        input  req_valid, req_is_load, req_funct3, req_addr_lo, req_rob_idx, req_pd, req_rd,
        input  cdb_ready,
        output req_ready,
        output cdb_valid, cdb_value, cdb_rob_idx, cdb_pd, cdb_rd
    );
endinterface

// File: rtl/load_resp.sv
// Load/store response stage: tracks one outstanding dmem access, formats load data, broadcasts on CDB.
// Optional RVFI tracing is enabled with the LOAD_RESP_RVFI_EN macro.

module load_resp #(
    parameter int ROB_IDX_W = 4,
    parameter int PREG_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    load_resp_if.slave  bus,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    input  logic        flush,
    output logic        busy
`ifdef LOAD_RESP_RVFI_EN
    ,
    input  load_resp_rvfi_pkg::rvfi_data rvfi_in,
    output load_resp_rvfi_pkg::rvfi_data rvfi_out
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BCAST = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t               state_reg, state_next;
    logic                 is_load_reg;
    logic [2:0]           funct3_reg;
    logic [1:0]           addr_lo_reg;
    logic [ROB_IDX_W-1:0] rob_idx_reg;
    logic [PREG_W-1:0]    pd_reg;
    logic [4:0]           rd_reg;
    logic [31:0]          value_reg, value_next;

    logic                 req_ready_int;
    logic                 accept;
    logic                 capture;

    logic [7:0]           lane_byte [4];
    logic [15:0]          lane_half [2];
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;

    // Byte and halfword lanes of the returning word, selected later by the latched address bits
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign lane_byte[gi] = dmem_rdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
            assign lane_half[gi] = dmem_rdata[16*gi +: 16];
        end
    endgenerate

    assign byte_sel = lane_byte[addr_lo_reg];
    assign half_sel = lane_half[addr_lo_reg[1]];

    always_comb begin
        value_next = 32'd0;
        if (is_load_reg) begin
            case (funct3_reg)
                F3_B:    value_next = {{24{byte_sel[7]}}, byte_sel};
                F3_H:    value_next = {{16{half_sel[15]}}, half_sel};
                F3_W:    value_next = dmem_rdata;
                F3_BU:   value_next = {24'd0, byte_sel};
                F3_HU:   value_next = {16'd0, half_sel};
                default: value_next = 32'd0;
            endcase
        end
    end

    assign req_ready_int = (state_reg == IDLE) && !flush;
    assign accept        = bus.req_valid && req_ready_int;
    assign capture       = (state_reg == WAIT) && dmem_resp && !flush;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_resp) begin
                    state_next = flush ? IDLE : BCAST;
                end else if (flush) begin
                    // The response is still coming; swallow it in DRAIN
                    state_next = DRAIN;
                end
            end
            BCAST: begin
                if (flush || bus.cdb_ready) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (dmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            is_load_reg <= 1'b0;
            funct3_reg  <= 3'd0;
            addr_lo_reg <= 2'd0;
            rob_idx_reg <= '0;
            pd_reg      <= '0;
            rd_reg      <= 5'd0;
            value_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                is_load_reg <= bus.req_is_load;
                funct3_reg  <= bus.req_funct3;
                addr_lo_reg <= bus.req_addr_lo;
                rob_idx_reg <= bus.req_rob_idx;
                pd_reg      <= bus.req_pd;
                // Stores write no architectural register
                rd_reg      <= bus.req_is_load ? bus.req_rd : 5'd0;
            end
            if (capture) begin
                value_reg <= value_next;
            end
        end
    end

    assign bus.req_ready   = req_ready_int;
    assign bus.cdb_valid   = (state_reg == BCAST) && !flush;
    assign bus.cdb_value   = value_reg;
    assign bus.cdb_rob_idx = rob_idx_reg;
    assign bus.cdb_pd      = pd_reg;
    assign bus.cdb_rd      = rd_reg;
    assign busy            = (state_reg != IDLE);

`ifdef LOAD_RESP_RVFI_EN
    load_resp_rvfi_pkg::rvfi_data rvfi_reg;
    logic [31:0]                  raw_rdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvfi_reg      <= '0;
            raw_rdata_reg <= 32'd0;
        end else begin
            if (accept) begin
                rvfi_reg <= rvfi_in;
            end
            if (capture) begin
                raw_rdata_reg <= dmem_rdata;
            end
        end
    end

    always_comb begin
        rvfi_out = '0;
        if (bus.cdb_valid) begin
            rvfi_out            = rvfi_reg;
            rvfi_out.dmem_rdata = raw_rdata_reg;
            rvfi_out.rd_wdata   = value_reg;
        end
    end
`endif

endmodule

// File: tb/tb_load_resp.sv
// Scoreboard bench for load_resp: stimulus pushes expected CDB results, a monitor pops on each handshake.

module tb_load_resp;

    logic        clk;
    logic        rst;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        flush;
    logic        busy;

    load_resp_if #(.ROB_IDX_W(4), .PREG_W(6)) bus ();

`ifdef LOAD_RESP_RVFI_EN
    load_resp_rvfi_pkg::rvfi_data rvfi_in;
    load_resp_rvfi_pkg::rvfi_data rvfi_out;
    assign rvfi_in = '0;
`endif

    load_resp #(.ROB_IDX_W(4), .PREG_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dmem_resp  (dmem_resp),
        .dmem_rdata (dmem_rdata),
        .flush      (flush),
        .busy       (busy)
`ifdef LOAD_RESP_RVFI_EN
        ,
        .rvfi_in    (rvfi_in),
        .rvfi_out   (rvfi_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [3:0]  rob;
        logic [5:0]  pd;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; stimulus checks land 2 units later
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every completed CDB handshake against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.cdb_valid && bus.cdb_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bcast actual=rob%0d value=0x%08h required=none",
                             bus.cdb_rob_idx, bus.cdb_value);
                end else begin
                    e = exp_q.pop_front();
                    chk("cdb_value",   bus.cdb_value, e.value);
                    chk("cdb_rob_idx", 32'(bus.cdb_rob_idx), 32'(e.rob));
                    chk("cdb_pd",      32'(bus.cdb_pd), 32'(e.pd));
                    chk("cdb_rd",      32'(bus.cdb_rd), 32'(e.rd));
                    $display("txn rob=%0d pd=%0d rd=%0d value=0x%08h",
                             bus.cdb_rob_idx, bus.cdb_pd, bus.cdb_rd, bus.cdb_value);
                end
            end
        end
    end

    task automatic accept(input logic il, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [3:0] rob, input logic [5:0] pd, input logic [4:0] rd);
        bus.req_valid   = 1'b1;
        bus.req_is_load = il;
        bus.req_funct3  = f3;
        bus.req_addr_lo = lo;
        bus.req_rob_idx = rob;
        bus.req_pd      = pd;
        bus.req_rd      = rd;
        #2;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        next();
        bus.req_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] data);
        dmem_resp  = 1'b1;
        dmem_rdata = data;
        next();
        dmem_resp  = 1'b0;
    endtask

    task automatic run_txn(input logic il, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [3:0] rob, input logic [5:0] pd, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic [31:0] exp_value,
                           input logic [4:0] exp_rd);
        exp_t e;
        e.value = exp_value;
        e.rob   = rob;
        e.pd    = pd;
        e.rd    = exp_rd;
        exp_q.push_back(e);
        accept(il, f3, lo, rob, pd, rd);
        resp(rdata);
        #2;
        chk("latency_cdb_valid", 32'(bus.cdb_valid), 32'd1);
        next();
        #2;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        dmem_resp       = 1'b0;
        dmem_rdata      = 32'd0;
        flush           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_is_load = 1'b0;
        bus.req_funct3  = 3'd0;
        bus.req_addr_lo = 2'd0;
        bus.req_rob_idx = 4'd0;
        bus.req_pd      = 6'd0;
        bus.req_rd      = 5'd0;
        bus.cdb_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_cdb_valid",   32'(bus.cdb_valid), 32'd0);
        chk("rst_cdb_value",   bus.cdb_value, 32'd0);
        chk("rst_cdb_rob_idx", 32'(bus.cdb_rob_idx), 32'd0);
        chk("rst_cdb_pd",      32'(bus.cdb_pd), 32'd0);
        chk("rst_cdb_rd",      32'(bus.cdb_rd), 32'd0);
        chk("rst_busy",        32'(busy), 32'd0);
        chk("rst_req_ready",   32'(bus.req_ready), 32'd1);
        next();

        // Load formatting, back-to-back at the 3-cycle rate
        run_txn(1'b1, 3'b000, 2'd3, 4'd2, 6'd10, 5'd3,  32'h80FF1234, 32'hFFFFFF80, 5'd3);
        run_txn(1'b1, 3'b101, 2'd2, 4'd4, 6'd11, 5'd4,  32'hBEEF0001, 32'h0000BEEF, 5'd4);
        run_txn(1'b1, 3'b001, 2'd2, 4'd6, 6'd12, 5'd5,  32'hBEEF0001, 32'hFFFFBEEF, 5'd5);
        run_txn(1'b1, 3'b100, 2'd2, 4'd1, 6'd13, 5'd6,  32'h80FF1234, 32'h000000FF, 5'd6);
        run_txn(1'b1, 3'b000, 2'd0, 4'd3, 6'd14, 5'd8,  32'h80FF1234, 32'h00000034, 5'd8);
        run_txn(1'b1, 3'b001, 2'd0, 4'd7, 6'd15, 5'd9,  32'h80FF1234, 32'h00001234, 5'd9);
        run_txn(1'b1, 3'b011, 2'd0, 4'd8, 6'd16, 5'd10, 32'h80FF1234, 32'h00000000, 5'd10);
        run_txn(1'b1, 3'b100, 2'd1, 4'd9, 6'd17, 5'd12, 32'h80FF1234, 32'h00000012, 5'd12);
        // Store: value and rd forced to zero, pd passed through
        run_txn(1'b0, 3'b010, 2'd0, 4'd5, 6'd9,  5'd7,  32'hDEADBEEF, 32'h00000000, 5'd0);

        // lw with the CDB stalled for 3 cycles
        begin
            exp_t e;
            e.value = 32'hCAFEF00D; e.rob = 4'd11; e.pd = 6'd33; e.rd = 5'd21;
            exp_q.push_back(e);
        end
        accept(1'b1, 3'b010, 2'd0, 4'd11, 6'd33, 5'd21);
        bus.cdb_ready = 1'b0;
        resp(32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_cdb_valid",   32'(bus.cdb_valid), 32'd1);
            chk("stall_cdb_value",   bus.cdb_value, 32'hCAFEF00D);
            chk("stall_cdb_rob_idx", 32'(bus.cdb_rob_idx), 32'd11);
            chk("stall_req_ready",   32'(bus.req_ready), 32'd0);
            next();
        end
        bus.cdb_ready = 1'b1;
        #2;
        chk("stall_release_valid", 32'(bus.cdb_valid), 32'd1);
        next();
        #2;
        chk("stall_after_req_ready", 32'(bus.req_ready), 32'd1);
        chk("stall_after_busy", 32'(busy), 32'd0);
        next();

        // Flush in WAIT, response two cycles later
        accept(1'b1, 3'b010, 2'd0, 4'd12, 6'd40, 5'd22);
        flush = 1'b1;
        #2;
        chk("flushw_req_ready", 32'(bus.req_ready), 32'd0);
        chk("flushw_busy", 32'(busy), 32'd1);
        next();
        flush = 1'b0;
        #2;
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        next();
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h11112222;
        #2;
        chk("drain_resp_busy", 32'(busy), 32'd1);
        chk("drain_resp_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        next();
        dmem_resp = 1'b0;
        #2;
        chk("drain_done_req_ready", 32'(bus.req_ready), 32'd1);
        chk("drain_done_busy", 32'(busy), 32'd0);
        chk("drain_done_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        next();

        // Flush together with the response in WAIT
        accept(1'b1, 3'b010, 2'd0, 4'd13, 6'd41, 5'd23);
        flush      = 1'b1;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h33334444;
        next();
        flush     = 1'b0;
        dmem_resp = 1'b0;
        #2;
        chk("flushresp_busy", 32'(busy), 32'd0);
        chk("flushresp_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        next();

        // Flush in BCAST drops the result
        accept(1'b1, 3'b010, 2'd0, 4'd14, 6'd42, 5'd24);
        resp(32'h55556666);
        flush = 1'b1;
        #2;
        chk("flushb_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        chk("flushb_req_ready", 32'(bus.req_ready), 32'd0);
        next();
        flush = 1'b0;
        #2;
        chk("flushb_busy", 32'(busy), 32'd0);
        chk("flushb_req_ready_after", 32'(bus.req_ready), 32'd1);
        next();

        // Flush and request in the same cycle: not accepted
        bus.req_valid   = 1'b1;
        bus.req_is_load = 1'b1;
        bus.req_funct3  = 3'b010;
        flush           = 1'b1;
        #2;
        chk("flushreq_req_ready", 32'(bus.req_ready), 32'd0);
        next();
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        #2;
        chk("flushreq_busy", 32'(busy), 32'd0);
        next();

        // Stray response in IDLE is ignored
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h77778888;
        next();
        dmem_resp = 1'b0;
        #2;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        next();

        // Reset in WAIT, response arrives afterwards
        accept(1'b1, 3'b010, 2'd0, 4'd15, 6'd50, 5'd25);
        rst = 1'b1;
        next();
        rst        = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h9999AAAA;
        #2;
        chk("midrst_busy",      32'(busy), 32'd0);
        chk("midrst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        chk("midrst_cdb_value", bus.cdb_value, 32'd0);
        chk("midrst_cdb_rob",   32'(bus.cdb_rob_idx), 32'd0);
        chk("midrst_cdb_pd",    32'(bus.cdb_pd), 32'd0);
        chk("midrst_cdb_rd",    32'(bus.cdb_rd), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        next();
        dmem_resp = 1'b0;
        #2;
        chk("midrst_resp_busy", 32'(busy), 32'd0);
        chk("midrst_resp_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        next();
        run_txn(1'b1, 3'b010, 2'd0, 4'd10, 6'd51, 5'd26, 32'h12345678, 32'h12345678, 5'd26);

        repeat (2) next();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
